// File: rtl/mult32_seq_pkg.sv
// mult32_seq_pkg: shared state encodings and iteration constants for mult32_seq
package mult32_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);
endpackage

// File: rtl/mult32_seq_shift32.sv
// shift32: 32-bit logical barrel shifter, LnR=1 shifts left, LnR=0 shifts right by S
module shift32 (
  input  logic [31:0] D,
  input  logic        LnR,
  input  logic [4:0]  S,
  output logic [31:0] Q
);
  assign Q = LnR ? D << S : D >> S;
endmodule

// File: rtl/mult32_seq.sv
// mult32_seq: sequential shift-add 32x32 multiplier, signed or unsigned, fixed 34-cycle latency
module mult32_seq
  import mult32_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_m, r_hi, r_lo;
  logic                 r_c, r_neg, r_done;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_lo_sh, w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0]   w_neg;
  assign w_abs_a = (SIGNED & A[WIDTH-1]) ? -A : A;
  assign w_abs_b = (SIGNED & B[WIDTH-1]) ? -B : B;
  assign w_sum   = r_lo[0] ? {r_c, r_hi} + {1'b0, r_m} : {1'b0, r_hi};
  assign w_neg   = -{r_hi, r_lo};
  shift32 u_shift (
    .D   (r_lo),
    .LnR (1'b0),
    .S   (5'd1),
    .Q   (w_lo_sh)
  );
  assign BUSY = (r_state == S_RUN) || (r_state == S_FIX);
  assign DONE = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;
  // state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next-state logic: 32 RUN cycles, one FIX cycle, one DONE cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = START ? S_RUN : S_IDLE;
      S_RUN:   w_next = (r_cnt == CNT_W'(ITERS - 1)) ? S_FIX : S_RUN;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // datapath: operand latch, shift-add iterations, sign fix-up; DONE pulse is registered off the DONE state
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_m    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_c    <= 1'b0;
      r_neg  <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: if (START) begin
          r_m   <= w_abs_a;
          r_lo  <= w_abs_b;
          r_hi  <= '0;
          r_c   <= 1'b0;
          r_neg <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
          r_cnt <= '0;
        end
        S_RUN: begin
          {r_c, r_hi} <= {1'b0, w_sum[WIDTH:1]};
          r_lo        <= w_lo_sh | {w_sum[0], {(WIDTH-1){1'b0}}};
          r_cnt       <= r_cnt + 1'b1;
        end
        S_FIX: if (r_neg) {r_hi, r_lo} <= w_neg;
        default: ;
      endcase
    end
  end
endmodule
